// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters,
// with a per-requester response register. Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module alu_share_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_in1,
  input  logic [32*NREQ-1:0]   req_in2,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [NREQ-1:0]      req_invert,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [32*NREQ-1:0]   rsp_result,
  output logic [NREQ-1:0]      rsp_zero,
  output logic [NREQ-1:0]      rsp_less_than,
  output logic                 alu_en,
  output logic [31:0]          alu_in1,
  output logic [31:0]          alu_in2,
  output logic [2:0]           alu_op,
  output logic                 alu_invert,
  input  logic [31:0]          alu_out,
  input  logic                 alu_zero,
  input  logic                 alu_less_than
);

  // Handshake: a request transfers in the cycle req_valid[i] and req_ready[i]
  // are both high; a response transfers when rsp_valid[i] and rsp_ready[i] are both high.
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;

  // A full slot being drained this cycle can accept a new result.
  assign eligible = req_valid & (~rsp_valid | rsp_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    if (!reset) grant = eligible & (~eligible + NREQ'(1));
  end
`else
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;

  // Walk the search order backwards so the last hit is the first index after ptr.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = ptr;
    if (!reset) begin
      for (int k = NREQ; k >= 1; k--) begin
        idx = (int'(ptr) + k) % NREQ;
        if (eligible[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          grant_idx  = PW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PW'(NREQ - 1);
    end else if (|grant) begin
      ptr <= grant_idx;
    end
  end
`endif

  assign req_ready = grant;
  assign alu_en    = |grant;

  // Grant is one-hot or zero, so OR-ing the masked fields selects the winner.
  always_comb begin
    alu_in1    = '0;
    alu_in2    = '0;
    alu_op     = '0;
    alu_invert = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_in1    = alu_in1 | req_in1[32*i +: 32];
        alu_in2    = alu_in2 | req_in2[32*i +: 32];
        alu_op     = alu_op | req_op[3*i +: 3];
        alu_invert = alu_invert | req_invert[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_zero      <= '0;
      rsp_less_than <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          rsp_valid[i]          <= 1'b1;
          rsp_result[32*i +: 32] <= alu_out;
          rsp_zero[i]           <= alu_zero;
          rsp_less_than[i]      <= alu_less_than;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Arbitrates one shared combinational ALU among `NREQ` requesters, such as the EX stage, the branch-compare path and the address-generation path. Each cycle it grants at most one eligible requester using round-robin order. It drives the granted operands into the ALU and captures the result into that requester's response register. Results return one cycle after grant on a per-requester valid/ready channel. The block sits between the requesting pipeline stages and the single ALU instance in EX.

## Interface
Parameters:
- `NREQ`, 2: number of requesters; legal range 2..8.

Ports (clock and reset first):
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: bit i indicates requester i presents an operation.
- `req_ready` out NREQ: bit i is high in the cycle requester i is granted.
- `req_in1` in 32*NREQ: operand 1; slice i is `[32*i+31:32*i]`.
- `req_in2` in 32*NREQ: operand 2; same slicing as `req_in1`.
- `req_op` in 3*NREQ: ALU opcode per requester, using the shared ALU encoding.
- `req_invert` in NREQ: invert/arithmetic-shift flag per requester.
- `rsp_valid` out NREQ: response register i holds a result.
- `rsp_ready` in NREQ: requester i consumes its response.
- `rsp_result` out 32*NREQ: captured ALU result per requester.
- `rsp_zero` out NREQ: captured zero flag.
- `rsp_less_than` out NREQ: captured less-than flag.
- `alu_en` out 1: drives the ALU's enable input. The ALU port is named `reset`, and the ALU outputs 0 when this input is low.
- `alu_in1` out 32, `alu_in2` out 32, `alu_op` out 3, `alu_invert` out 1: operands and control to the ALU.
- `alu_out` in 32, `alu_zero` in 1, `alu_less_than` in 1: combinational ALU results.

## Operation
- Eligibility: requester i is eligible when `req_valid[i]` is high and either `rsp_valid[i]` is low or `rsp_ready[i]` is high. A full slot that is being drained in the same cycle is therefore eligible.
- Grant:
  - One-hot or zero.
  - The search starts at index `ptr+1` (mod NREQ) and takes the first eligible index.
  - `ptr` updates to the granted index on each grant and holds otherwise.
- `req_ready = grant`. This output is combinational and depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- ALU mux:
  - On a grant: `alu_en` = 1 and the ALU inputs carry the granted requester's fields.
  - With no grant: `alu_en` = 0 and all ALU inputs are driven to 0.
- Response register i, updated at each clock edge:
  - If granted: load `alu_out`, `alu_zero` and `alu_less_than`, and set `rsp_valid[i]` = 1.
  - Else, if `rsp_valid[i]` and `rsp_ready[i]` are both high: clear `rsp_valid[i]`. The data fields hold.
  - Otherwise: hold all fields.
- While `rsp_valid[i]` is high and `rsp_ready[i]` is low, all `rsp_*[i]` outputs are stable.
- There is no result arithmetic in this block. Widths pass through unchanged: 32-bit operands, a 3-bit opcode and 1-bit flags.

## Timing
- Latency: an operation granted in cycle N has `rsp_valid` high in cycle N+1.
- Throughput: one ALU operation per cycle in aggregate. A single requester sustains one per cycle if it holds `rsp_ready` high.
- Simultaneous drain and grant on the same slot: the new result loads and `rsp_valid` stays 1 with no bubble.
- Contention with all NREQ requesters continuously eligible: grants rotate 0,1,…,NREQ-1,0,… Each requester waits at most NREQ-1 cycles.
- Reset, sampled at a clock edge:
  - `rsp_valid`, `rsp_result`, `rsp_zero` and `rsp_less_than` all go to 0.
  - `ptr` goes to NREQ-1, so requester 0 has first priority.
  - While `reset` is high, `req_ready` = 0 and `alu_en` = 0, regardless of inputs.
- Reset asserted while responses are pending: those results are discarded and are not delivered after reset.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: grant goes to the lowest eligible index. `ptr` is not implemented, and a lower index can starve higher ones.
  - Undefined (default): round-robin as specified above.
- All other behaviour is identical in both builds.

## Test plan
- Single op, NREQ=2. Req0: in1=5, in2=3, op=000, invert=0 in cycle N. Expect `req_ready`=01 in N, then in N+1 `rsp_valid[0]`=1, `rsp_result[0]`=8, zero=0.
- Contention. Both requesters valid every cycle with `rsp_ready`=11 from reset. Expect grants 0,1,0,1, and each result lands in the correct slot. Under `ALU_ARB_FIXED_PRIO_EN`, expect grants 0,0,0,0.
- Backpressure. Req1 is granted a SUB-based compare (op=010, invert=1, in1=2, in2=7) with `rsp_ready[1]`=0. Expect `rsp_less_than[1]`=1 and `rsp_result[1]`=1, held stable. Req1 is not granted again until `rsp_ready[1]`=1.
- Drain plus grant in the same cycle. `rsp_valid[0]`=1, `rsp_ready[0]`=1 and a new req0 XOR (in1=0xFF, in2=0xFF). Expect `rsp_valid[0]` to stay 1 with result 0 and zero=1 the next cycle.
- Idle. All `req_valid`=0. Expect `alu_en`=0, `alu_in1`/`alu_in2`=0, and no `rsp_valid` change.
- Reset mid-operation. Grant req0 in cycle N and assert `reset` in N+1. Expect all `rsp_valid`=0 after the edge. The first post-reset contention grants req0.
